// File: rtl/sample_replay_queue.sv
// Purpose : holds a small training set (feature vector + label) loaded by the host and
//           replays it one sample per write_en rising edge for EPOCHS passes, then flags done.
// Latency : a sample is presented on the clock edge that enters PLAY or sees a write_en rising edge.
// Backpr. : wr_ready is high only while loading (IDLE/LOAD) with free space; low in PLAY/DONE.
//
// Ports:
//   clk, reset (async active-low), flush (sync clear)
//   wr_valid/wr_ready/wr_data/wr_label/wr_last : host load port
//   start    : begin/restart replay          write_en : advance request (rising edge used)
//   Xin/label_out/sample_valid : current sample  epoch_done : pulse at each dataset wrap
//   done     : all epochs replayed            count    : number of samples stored
module sample_replay_queue #(
    parameter int DATA_W  = 7,
    parameter int LABEL_W = 3,
    parameter int DEPTH   = 16,
    parameter int EPOCHS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [LABEL_W-1:0]        wr_label,
    input  logic                      wr_last,
    input  logic                      start,
    input  logic                      write_en,
    output logic [DATA_W-1:0]         Xin,
    output logic [LABEL_W-1:0]        label_out,
    output logic                      sample_valid,
    output logic                      epoch_done,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + LABEL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [PTR_W-1:0]       rd_ptr, rd_ptr_nxt;
    logic [7:0]             epoch, epoch_nxt;
    logic [7:0]             epoch_inc;
    logic [DATA_W-1:0]      xin_nxt;
    logic [LABEL_W-1:0]     label_nxt;
    logic                   sample_valid_nxt;
    logic                   epoch_done_nxt;
    logic                   done_nxt;
    logic                   write_en_q;
    logic                   adv;
    logic                   wr_fire;
    logic [CNT_W-1:0]       next_idx;
    logic [ENT_W-1:0]       head_ent;
    logic [ENT_W-1:0]       next_ent;

    // Dataset storage; entries at or above count are never read, so no reset is needed.
    logic [ENT_W-1:0]       mem [DEPTH];

    assign wr_ready  = ((state == S_IDLE) || (state == S_LOAD)) && (count < CNT_W'(DEPTH));
    assign wr_fire   = wr_valid & wr_ready;
    assign adv       = write_en & ~write_en_q;
    assign next_idx  = {1'b0, rd_ptr} + CNT_W'(1);
    assign head_ent  = mem[0];
    // When next_idx reaches DEPTH the truncated index aliases entry 0, but that read
    // is only used when next_idx < count, so the alias is never observed.
    assign next_ent  = mem[next_idx[PTR_W-1:0]];
    assign epoch_inc = epoch + 8'd1;

    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[count[PTR_W-1:0]] <= {wr_data, wr_label};
        end
    end

    // Next-state and next-output logic. Each branch that (re)starts replay presents entry 0.
    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        rd_ptr_nxt       = rd_ptr;
        epoch_nxt        = epoch;
        xin_nxt          = Xin;
        label_nxt        = label_out;
        sample_valid_nxt = sample_valid;
        epoch_done_nxt   = 1'b0;
        done_nxt         = done;

        if (flush) begin
            state_nxt        = S_IDLE;
            count_nxt        = '0;
            rd_ptr_nxt       = '0;
            epoch_nxt        = '0;
            xin_nxt          = '0;
            label_nxt        = '0;
            sample_valid_nxt = 1'b0;
            done_nxt         = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // start with an empty dataset is deliberately ignored here
                    if (wr_fire) begin
                        count_nxt = count + CNT_W'(1);
                        state_nxt = S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (wr_fire) begin
                        count_nxt = count + CNT_W'(1);
                    end
                    // count is at least 1 in LOAD, so entry 0 is already valid even
                    // when the closing write lands on this same edge.
                    if ((wr_fire && (wr_last || (count == CNT_W'(DEPTH - 1)))) || start) begin
                        state_nxt        = S_PLAY;
                        rd_ptr_nxt       = '0;
                        epoch_nxt        = '0;
                        xin_nxt          = head_ent[ENT_W-1:LABEL_W];
                        label_nxt        = head_ent[LABEL_W-1:0];
                        sample_valid_nxt = 1'b1;
                    end
                end

                S_PLAY: begin
                    if (start) begin
                        rd_ptr_nxt       = '0;
                        epoch_nxt        = '0;
                        xin_nxt          = head_ent[ENT_W-1:LABEL_W];
                        label_nxt        = head_ent[LABEL_W-1:0];
                        sample_valid_nxt = 1'b1;
                    end else if (adv) begin
                        if (next_idx < count) begin
                            rd_ptr_nxt = next_idx[PTR_W-1:0];
                            xin_nxt    = next_ent[ENT_W-1:LABEL_W];
                            label_nxt  = next_ent[LABEL_W-1:0];
                        end else begin
                            rd_ptr_nxt     = '0;
                            epoch_done_nxt = 1'b1;
                            epoch_nxt      = epoch_inc;
                            if (epoch_inc == 8'(EPOCHS)) begin
                                state_nxt        = S_DONE;
                                xin_nxt          = '0;
                                label_nxt        = '0;
                                sample_valid_nxt = 1'b0;
                                done_nxt         = 1'b1;
                            end else begin
                                xin_nxt   = head_ent[ENT_W-1:LABEL_W];
                                label_nxt = head_ent[LABEL_W-1:0];
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state_nxt        = S_PLAY;
                        rd_ptr_nxt       = '0;
                        epoch_nxt        = '0;
                        xin_nxt          = head_ent[ENT_W-1:LABEL_W];
                        label_nxt        = head_ent[LABEL_W-1:0];
                        sample_valid_nxt = 1'b1;
                        done_nxt         = 1'b0;
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            epoch        <= '0;
            Xin          <= '0;
            label_out    <= '0;
            sample_valid <= 1'b0;
            epoch_done   <= 1'b0;
            done         <= 1'b0;
            write_en_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            rd_ptr       <= rd_ptr_nxt;
            epoch        <= epoch_nxt;
            Xin          <= xin_nxt;
            label_out    <= label_nxt;
            sample_valid <= sample_valid_nxt;
            epoch_done   <= epoch_done_nxt;
            done         <= done_nxt;
            // edge detector keeps tracking through flush so a held write_en stays one request
            write_en_q   <= write_en;
        end
    end

endmodule

// File: tb/tb_sample_replay_queue.sv
// Purpose : self-checking bench for sample_replay_queue against a dataset/epoch model.
// Latency : all inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpr. : host writes are offered every cycle; the model decides whether they are taken.
module tb_sample_replay_queue;

    localparam int DATA_W  = 7;
    localparam int LABEL_W = 3;
    localparam int DEPTH   = 16;
    localparam int EPOCHS  = 2;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [DATA_W-1:0]  wr_data;
    logic [LABEL_W-1:0] wr_label;
    logic               wr_last;
    logic               start;
    logic               write_en;
    logic [DATA_W-1:0]  Xin;
    logic [LABEL_W-1:0] label_out;
    logic               sample_valid;
    logic               epoch_done;
    logic               done;
    logic [4:0]         count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the dataset as two queues plus replay position and mode flags.
    logic [DATA_W-1:0]  m_data[$];
    logic [LABEL_W-1:0] m_lab[$];
    int                 m_pos;
    int                 m_epoch;
    bit                 m_play;
    bit                 m_done;

    sample_replay_queue #(
        .DATA_W (DATA_W),
        .LABEL_W(LABEL_W),
        .DEPTH  (DEPTH),
        .EPOCHS (EPOCHS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_label    (wr_label),
        .wr_last     (wr_last),
        .start       (start),
        .write_en    (write_en),
        .Xin         (Xin),
        .label_out   (label_out),
        .sample_valid(sample_valid),
        .epoch_done  (epoch_done),
        .done        (done),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_ready();
        return !m_play && !m_done && (m_data.size() < DEPTH);
    endfunction

    task automatic model_clear();
        m_data.delete();
        m_lab.delete();
        m_pos   = 0;
        m_epoch = 0;
        m_play  = 0;
        m_done  = 0;
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0]  ex;
        logic [LABEL_W-1:0] el;
        ex = m_play ? m_data[m_pos] : '0;
        el = m_play ? m_lab[m_pos]  : '0;
        chk({tag, "/xin"},   32'(Xin),          32'(ex));
        chk({tag, "/label"}, 32'(label_out),    32'(el));
        chk({tag, "/valid"}, 32'(sample_valid), 32'(m_play));
        chk({tag, "/done"},  32'(done),         32'(m_done));
        chk({tag, "/count"}, 32'(count),        32'(m_data.size()));
        chk({tag, "/ready"}, 32'(wr_ready),     32'(model_ready()));
    endtask

    // One host write attempt lasting a single cycle.
    task automatic try_write(input string tag, input logic [DATA_W-1:0] d,
                             input logic [LABEL_W-1:0] l, input bit last);
        bit was_loading;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_label = l;
        wr_last  = last;
        chk({tag, "/ready_pre"}, 32'(wr_ready), 32'(model_ready()));
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (model_ready()) begin
            was_loading = (m_data.size() > 0);
            m_data.push_back(d);
            m_lab.push_back(l);
            if (was_loading && (last || m_data.size() == DEPTH)) begin
                m_play  = 1;
                m_pos   = 0;
                m_epoch = 0;
            end
        end
    endtask

    task automatic pulse_we(input string tag, input int hold);
        bit wrap;
        wrap = 0;
        write_en = 1'b1;
        tick();
        if (m_play) begin
            if (m_pos + 1 < m_data.size()) begin
                m_pos++;
            end else begin
                wrap = 1;
                m_pos = 0;
                m_epoch++;
                if (m_epoch == EPOCHS) begin
                    m_play = 0;
                    m_done = 1;
                end
            end
        end
        chk({tag, "/edone"}, 32'(epoch_done), 32'(wrap));
        for (int i = 1; i < hold; i++) tick();
        write_en = 1'b0;
        tick();
        chk({tag, "/edone_after"}, 32'(epoch_done), 32'(0));
        check_all(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_play || m_done || m_data.size() > 0) begin
            m_play  = 1;
            m_done  = 0;
            m_pos   = 0;
            m_epoch = 0;
        end
        chk({tag, "/edone"}, 32'(epoch_done), 32'(0));
        check_all(tag);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        check_all(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] seq [6];
        int n;
        bit use_last;

        reset    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_label = '0;
        wr_last  = 1'b0;
        start    = 1'b0;
        write_en = 1'b0;
        model_clear();

        // reset state, including wr_ready high while reset is held
        repeat (3) tick();
        check_all("reset");
        chk("reset/edone", 32'(epoch_done), 32'(0));
        #2 reset = 1'b1;
        tick();

        // directed 3-sample load with wr_last on the third
        try_write("ld0", 7'h01, 3'd1, 1'b0);
        try_write("ld1", 7'h2A, 3'd2, 1'b0);
        try_write("ld2", 7'h7F, 3'd5, 1'b1);
        check_all("ld_done");
        chk("ld_done/xin_lit", 32'(Xin), 32'h01);
        chk("ld_done/count_lit", 32'(count), 32'd3);

        // two epochs of three samples; literal expected Xin after each pulse
        seq[0] = 7'h2A; seq[1] = 7'h7F; seq[2] = 7'h01;
        seq[3] = 7'h2A; seq[4] = 7'h7F; seq[5] = 7'h00;
        for (int i = 0; i < 6; i++) begin
            pulse_we($sformatf("rep%0d", i), 1);
            chk($sformatf("rep%0d/xin_lit", i), 32'(Xin), 32'(seq[i]));
        end

        // restart from DONE: identical replay
        do_start("restart");
        for (int i = 0; i < 6; i++) begin
            pulse_we($sformatf("rerep%0d", i), 1);
            chk($sformatf("rerep%0d/xin_lit", i), 32'(Xin), 32'(seq[i]));
        end

        // flush in DONE
        do_flush("flush_done");

        // fill to DEPTH without wr_last, then a rejected 17th write
        for (int i = 0; i < DEPTH; i++)
            try_write($sformatf("fill%0d", i), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        check_all("full");
        try_write("over", 7'h55, 3'd3, 1'b0);
        check_all("over");

        // held write_en gives exactly one advance
        pulse_we("hold", 10);

        // write_en in LOAD has no effect, start leaves LOAD
        do_flush("flush_load");
        try_write("l0", 7'h11, 3'd1, 1'b0);
        try_write("l1", 7'h22, 3'd2, 1'b0);
        pulse_we("we_in_load", 2);
        do_start("start_load");

        // randomized rounds
        for (int r = 0; r < 12; r++) begin
            do_flush($sformatf("r%0d/flush", r));
            n = $urandom_range(1, DEPTH);
            use_last = (n > 1) && (n < DEPTH) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++)
                try_write($sformatf("r%0d/wr%0d", r, i), 7'($urandom_range(0, 127)),
                          3'($urandom_range(0, 7)), use_last && (i == n - 1));
            if (!m_play) begin
                pulse_we($sformatf("r%0d/we_load", r), 1);
                do_start($sformatf("r%0d/start", r));
            end
            for (int k = 0; k < 2 * n * EPOCHS + 4; k++) begin
                if ($urandom_range(0, 15) == 0) do_start($sformatf("r%0d/s%0d", r, k));
                else pulse_we($sformatf("r%0d/p%0d", r, k), $urandom_range(1, 3));
            end
        end

        // async reset mid-PLAY at sample 2
        do_flush("flush_ar");
        try_write("a0", 7'h03, 3'd1, 1'b0);
        try_write("a1", 7'h0C, 3'd2, 1'b0);
        try_write("a2", 7'h30, 3'd4, 1'b1);
        pulse_we("a_p0", 1);
        pulse_we("a_p1", 1);
        chk("a_at2/xin_lit", 32'(Xin), 32'h30);
        #3 reset = 1'b0;
        #1;
        model_clear();
        check_all("areset");
        chk("areset/edone", 32'(epoch_done), 32'(0));
        #2 reset = 1'b1;
        tick();
        check_all("post_areset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
